// File: rtl/ex_hazard_ctrl.sv
// Execute-stage hazard controller: operand forwarding, load-use stall,
// taken-branch flush and stall sequencing for iterative mul/div ops.
module ex_hazard_ctrl #(
    parameter int MC_LATENCY = 4,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] Rs1_D,
    input  logic [4:0] Rs2_D,
    input  logic [4:0] Rs1_E,
    input  logic [4:0] Rs2_E,
    input  logic [4:0] Rd_E,
    input  logic       MemRead_E,
    input  logic       MultiCycle_E,
    input  logic       PCSrc_E,
    input  logic [4:0] Rd_M,
    input  logic       RegWrite_M,
    input  logic [4:0] Rd_W,
    input  logic       RegWrite_W,
    output logic [1:0] ForwardA,
    output logic [1:0] ForwardB,
    output logic       Stall_F,
    output logic       Stall_D,
    output logic       Stall_E,
    output logic       Flush_D,
    output logic       Flush_E,
    output logic       Bubble_M,
    output logic       MC_Start,
    output logic       MC_Done,
    output logic       Busy
);

    // The start cycle itself is one EX cycle, so the counter loads LATENCY-2.
    localparam int   CNT_LOAD = (MC_LATENCY > 1) ? (MC_LATENCY - 2) : 0;
    localparam logic MC_MULTI = (MC_LATENCY > 1);

    typedef enum logic {RUN, MC_BUSY} state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_nextCnt;
    logic             w_loadUse;

    function automatic logic [1:0] fwdSel(input logic [4:0] rs);
        if (RegWrite_M && (Rd_M != 5'd0) && (Rd_M == rs))
            return 2'b10;
        else if (RegWrite_W && (Rd_W != 5'd0) && (Rd_W == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign ForwardA  = fwdSel(Rs1_E);
    assign ForwardB  = fwdSel(Rs2_E);
    assign w_loadUse = MemRead_E && (Rd_E != 5'd0) &&
                       ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        case (r_state)
            RUN: begin
                if (!PCSrc_E && MultiCycle_E && MC_MULTI) begin
                    w_nextState = MC_BUSY;
                    w_nextCnt   = CNT_W'(CNT_LOAD);
                end
            end
            MC_BUSY: begin
                if (r_cnt != '0)
                    w_nextCnt = r_cnt - 1'b1;
                else
                    w_nextState = RUN;
            end
            default: begin
                w_nextState = RUN;
                w_nextCnt   = '0;
            end
        endcase
    end

    // A branch in EX outranks a multi-cycle start, which outranks load-use.
    always_comb begin
        Stall_F  = 1'b0;
        Stall_D  = 1'b0;
        Stall_E  = 1'b0;
        Flush_D  = 1'b0;
        Flush_E  = 1'b0;
        Bubble_M = 1'b0;
        MC_Start = 1'b0;
        MC_Done  = 1'b0;
        Busy     = 1'b0;
        case (r_state)
            RUN: begin
                if (PCSrc_E) begin
                    Flush_D = 1'b1;
                    Flush_E = 1'b1;
                end else if (MultiCycle_E) begin
                    MC_Start = 1'b1;
                    if (MC_MULTI) begin
                        Stall_F  = 1'b1;
                        Stall_D  = 1'b1;
                        Stall_E  = 1'b1;
                        Bubble_M = 1'b1;
                    end else begin
                        MC_Done = 1'b1;
                    end
                end else if (w_loadUse) begin
                    Stall_F = 1'b1;
                    Stall_D = 1'b1;
                    Flush_E = 1'b1;
                end
            end
            MC_BUSY: begin
                Busy = 1'b1;
                if (r_cnt != '0) begin
                    Stall_F  = 1'b1;
                    Stall_D  = 1'b1;
                    Stall_E  = 1'b1;
                    Bubble_M = 1'b1;
                end else begin
                    MC_Done = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed, table-driven bench for ex_hazard_ctrl; one extra instance with
// MC_LATENCY=1 covers the single-cycle multi-cycle boundary.
module tb_ex_hazard_ctrl;

    // Expected vector layout: {ForwardA, ForwardB, Stall_F, Stall_D, Stall_E,
    // Flush_D, Flush_E, Bubble_M, MC_Start, MC_Done, Busy}
    typedef struct {
        string       name;
        logic        rst;
        logic [4:0]  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
        logic        memRead, multi, pcSrc, regWriteM, regWriteW;
        logic [12:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       memRead, multi, pcSrc, regWriteM, regWriteW;

    logic [1:0] fwdA, fwdB, fwdA1, fwdB1;
    logic       stallF, stallD, stallE, flushD, flushE, bubbleM, mcStart, mcDone, busy;
    logic       stallF1, stallD1, stallE1, flushD1, flushE1, bubbleM1, mcStart1, mcDone1, busy1;

    int testsRun = 0;
    int testsFailed = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    ex_hazard_ctrl #(.MC_LATENCY(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .Rs1_D(rs1D), .Rs2_D(rs2D), .Rs1_E(rs1E), .Rs2_E(rs2E), .Rd_E(rdE),
        .MemRead_E(memRead), .MultiCycle_E(multi), .PCSrc_E(pcSrc),
        .Rd_M(rdM), .RegWrite_M(regWriteM), .Rd_W(rdW), .RegWrite_W(regWriteW),
        .ForwardA(fwdA), .ForwardB(fwdB),
        .Stall_F(stallF), .Stall_D(stallD), .Stall_E(stallE),
        .Flush_D(flushD), .Flush_E(flushE), .Bubble_M(bubbleM),
        .MC_Start(mcStart), .MC_Done(mcDone), .Busy(busy)
    );

    ex_hazard_ctrl #(.MC_LATENCY(1), .CNT_W(4)) dut1 (
        .clk(clk), .reset(reset),
        .Rs1_D(rs1D), .Rs2_D(rs2D), .Rs1_E(rs1E), .Rs2_E(rs2E), .Rd_E(rdE),
        .MemRead_E(memRead), .MultiCycle_E(multi), .PCSrc_E(pcSrc),
        .Rd_M(rdM), .RegWrite_M(regWriteM), .Rd_W(rdW), .RegWrite_W(regWriteW),
        .ForwardA(fwdA1), .ForwardB(fwdB1),
        .Stall_F(stallF1), .Stall_D(stallD1), .Stall_E(stallE1),
        .Flush_D(flushD1), .Flush_E(flushE1), .Bubble_M(bubbleM1),
        .MC_Start(mcStart1), .MC_Done(mcDone1), .Busy(busy1)
    );

    function automatic vec_t mk(string name, logic rst,
                                logic [4:0] rs1D_, logic [4:0] rs2D_,
                                logic [4:0] rs1E_, logic [4:0] rs2E_, logic [4:0] rdE_,
                                logic memRead_, logic multi_, logic pcSrc_,
                                logic [4:0] rdM_, logic regWriteM_,
                                logic [4:0] rdW_, logic regWriteW_,
                                logic [12:0] exp_);
        vec_t v;
        v.name = name;   v.rst = rst;
        v.rs1D = rs1D_;  v.rs2D = rs2D_; v.rs1E = rs1E_; v.rs2E = rs2E_; v.rdE = rdE_;
        v.memRead = memRead_; v.multi = multi_; v.pcSrc = pcSrc_;
        v.rdM = rdM_; v.regWriteM = regWriteM_; v.rdW = rdW_; v.regWriteW = regWriteW_;
        v.exp = exp_;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        reset     = v.rst;
        rs1D      = v.rs1D;  rs2D = v.rs2D;
        rs1E      = v.rs1E;  rs2E = v.rs2E;
        rdE       = v.rdE;   memRead = v.memRead;
        multi     = v.multi; pcSrc = v.pcSrc;
        rdM       = v.rdM;   regWriteM = v.regWriteM;
        rdW       = v.rdW;   regWriteW = v.regWriteW;
    endtask

    task automatic checkOutput(input string name, input logic [12:0] act, input logic [12:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    initial begin
        vec_t idle;
        idle = mk("idle", 0, 0,0,0,0,0, 0,0,0, 0,0, 0,0, 13'b0);

        // Single-cycle behaviour in RUN, forwarding and hazard priorities.
        vecs.push_back(mk("idle",          0, 0,0, 0,0, 0, 0,0,0,  0,0, 0,0, 13'b0));
        vecs.push_back(mk("fwdA_mem",      0, 0,0, 5,0, 0, 0,0,0,  5,1, 5,1, {2'b10,2'b00,9'b0}));
        vecs.push_back(mk("fwdA_wb",       0, 0,0, 5,0, 0, 0,0,0,  5,0, 5,1, {2'b01,2'b00,9'b0}));
        vecs.push_back(mk("fwd_x0",        0, 0,0, 0,0, 0, 0,0,0,  0,1, 0,1, 13'b0));
        vecs.push_back(mk("fwdB_mem_A_wb", 0, 0,0, 3,9, 0, 0,0,0,  9,1, 3,1, {2'b01,2'b10,9'b0}));
        vecs.push_back(mk("fwd_wb_off",    0, 0,0, 5,5, 0, 0,0,0,  6,1, 5,0, 13'b0));
        vecs.push_back(mk("loaduse_rs2",   0, 0,7, 0,0, 7, 1,0,0,  0,0, 0,0, {4'b0,9'b110010000}));
        vecs.push_back(mk("loaduse_after", 0, 0,0, 0,0, 0, 0,0,0,  0,0, 0,0, 13'b0));
        vecs.push_back(mk("loaduse_x0",    0, 0,0, 0,0, 0, 1,0,0,  0,0, 0,0, 13'b0));
        vecs.push_back(mk("loaduse_rs1",   0, 12,3, 0,0, 12, 1,0,0, 0,0, 0,0, {4'b0,9'b110010000}));
        vecs.push_back(mk("branch_lu",     0, 0,7, 0,0, 7, 1,0,1,  0,0, 0,0, {4'b0,9'b000110000}));
        vecs.push_back(mk("branch_mc",     0, 0,0, 0,0, 0, 0,1,1,  0,0, 0,0, {4'b0,9'b000110000}));
        vecs.push_back(mk("branch_mc_run", 0, 0,0, 0,0, 0, 0,0,0,  0,0, 0,0, 13'b0));
        // Multi-cycle op, MC_LATENCY=4; load-use and branch in EX ignored while busy.
        vecs.push_back(mk("mc_t0",         0, 0,0, 5,0, 0, 0,1,0,  5,1, 0,0, {2'b10,2'b00,9'b111001100}));
        vecs.push_back(mk("mc_t1",         0, 0,7, 5,0, 7, 1,1,0,  5,1, 0,0, {2'b10,2'b00,9'b111001001}));
        vecs.push_back(mk("mc_t2",         0, 0,0, 0,0, 0, 0,1,1,  0,0, 0,0, {4'b0,9'b111001001}));
        vecs.push_back(mk("mc_t3_done",    0, 0,0, 0,0, 0, 0,1,0,  0,0, 0,0, {4'b0,9'b000000011}));
        vecs.push_back(mk("mc_t4_run",     0, 0,0, 0,0, 0, 0,0,0,  0,0, 0,0, 13'b0));
        // Reset in the middle of an op aborts it without MC_Done.
        vecs.push_back(mk("rst_t0",        0, 0,0, 0,0, 0, 0,1,0,  0,0, 0,0, {4'b0,9'b111001100}));
        vecs.push_back(mk("rst_t1",        1, 0,0, 0,0, 0, 0,1,0,  0,0, 0,0, {4'b0,9'b111001001}));
        vecs.push_back(mk("rst_t2",        0, 0,0, 0,0, 0, 0,0,0,  0,0, 0,0, 13'b0));
        vecs.push_back(mk("rst_t3",        0, 0,0, 0,0, 0, 0,0,0,  0,0, 0,0, 13'b0));
        vecs.push_back(mk("rst_t4",        0, 0,0, 0,0, 0, 0,0,0,  0,0, 0,0, 13'b0));

        applyStimulus(idle);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_state",
                    {fwdA, fwdB, stallF, stallD, stallE, flushD, flushE, bubbleM, mcStart, mcDone, busy},
                    13'b0);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput(vecs[i].name,
                        {fwdA, fwdB, stallF, stallD, stallE, flushD, flushE, bubbleM, mcStart, mcDone, busy},
                        vecs[i].exp);
        end

        // MC_LATENCY=1: start and done in one cycle, no stall, stays in RUN.
        @(posedge clk);
        #1;
        applyStimulus(mk("lat1", 0, 0,0, 0,0, 0, 0,1,0, 0,0, 0,0, 13'b0));
        @(negedge clk);
        checkOutput("lat1_start_done",
                    {fwdA1, fwdB1, stallF1, stallD1, stallE1, flushD1, flushE1, bubbleM1, mcStart1, mcDone1, busy1},
                    {4'b0, 9'b000000110});
        @(posedge clk);
        #1;
        applyStimulus(idle);
        @(negedge clk);
        checkOutput("lat1_after",
                    {fwdA1, fwdB1, stallF1, stallD1, stallE1, flushD1, flushE1, bubbleM1, mcStart1, mcDone1, busy1},
                    13'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/ex_hazard_ctrl.md
Name: ex_hazard_ctrl

Overview:
- Hazard and sequencing controller for the execute stage of the 5-stage RV32I pipeline.
- Generates the ForwardA/ForwardB selects that drive the EX operand muxes.
- Detects load-use hazards and flushes on taken branches (PCSrc from EX).
- Sequences multi-cycle EX operations (iterative mul/div) with a counter FSM that holds IF/ID/EX and bubbles EX/MEM until the operation completes.

Parameters:
- MC_LATENCY, 4, total EX-stage cycles for a multi-cycle op; legal range 1..16. A value of 1 means treat the op as single-cycle.
- CNT_W, 4, width of the internal busy counter; must satisfy 2^CNT_W > MC_LATENCY.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset, sampled on posedge clk
- Rs1_D, Rs2_D  in  5  source registers of the instruction in ID
- Rs1_E, Rs2_E  in  5  source registers of the instruction in EX
- Rd_E  in  5  destination register of the instruction in EX
- MemRead_E  in  1  EX instruction is a load
- MultiCycle_E  in  1  EX instruction needs MC_LATENCY cycles
- PCSrc_E  in  1  taken branch resolved in EX
- Rd_M, RegWrite_M  in  5/1  MEM-stage destination and write enable
- Rd_W, RegWrite_W  in  5/1  WB-stage destination and write enable
- ForwardA, ForwardB  out  2  operand select: 00 regfile, 01 Result_W, 10 ALUResult_M
- Stall_F, Stall_D, Stall_E  out  1  hold the PC, IF/ID and ID/EX registers
- Flush_D, Flush_E  out  1  clear IF/ID and ID/EX to a bubble
- Bubble_M  out  1  load zero control signals into EX/MEM this cycle
- MC_Start  out  1  one-cycle pulse; the mul/div unit samples its operands on this cycle
- MC_Done  out  1  final EX cycle of a multi-cycle op; the result is valid
- Busy  out  1  FSM is in MC_BUSY

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-high. On reset the FSM goes to RUN and cnt is cleared to 0.
- Outputs are combinational from (state, cnt, inputs). Only state and cnt are registered.
- Reset value of every output: 0, with all inputs at 0.

Forwarding (evaluated every cycle, in every state):
- ForwardA = 10 if RegWrite_M && Rd_M!=0 && Rd_M==Rs1_E.
- Else ForwardA = 01 if RegWrite_W && Rd_W!=0 && Rd_W==Rs1_E.
- Else ForwardA = 00.
- ForwardB is identical using Rs2_E. The MEM stage has priority over WB.
- Code 11 is never driven.

FSM states: RUN, MC_BUSY.

RUN:
- Priority order: PCSrc_E > MultiCycle_E > load-use.
- If PCSrc_E: assert Flush_D and Flush_E. No stalls. Stay in RUN. Any simultaneous MultiCycle_E or load-use is ignored.
- Else if MultiCycle_E && MC_LATENCY>1:
  - Assert MC_Start, Stall_F, Stall_D, Stall_E and Bubble_M.
  - Next state MC_BUSY; cnt <= MC_LATENCY-2.
- Else if MultiCycle_E && MC_LATENCY==1: assert MC_Start and MC_Done in the same cycle. No stall. Stay in RUN.
- Else if MemRead_E && Rd_E!=0 && (Rd_E==Rs1_D || Rd_E==Rs2_D) (load-use):
  - Assert Stall_F, Stall_D and Flush_E for exactly one cycle.
  - Stay in RUN. The following cycle the load is in MEM and forwarding takes over.

MC_BUSY:
- If cnt!=0: assert Stall_F, Stall_D, Stall_E and Bubble_M; cnt <= cnt-1.
- If cnt==0: assert MC_Done. No stalls and no bubble. Next state RUN. The op leaves EX at the end of this cycle.
- Load-use, PCSrc_E and MultiCycle_E are ignored in this state; the instruction held in EX is not a branch.
- The op therefore occupies EX for exactly MC_LATENCY cycles: MC_LATENCY-1 stalled cycles plus 1 release cycle.
- No re-trigger: the cycle after MC_Done is RUN and sees the next instruction.

Other rules:
- Forwarded values can disappear while the pipeline is bubbled. For this reason the mul/div unit must capture its operands on MC_Start only.
- Stall_E is never asserted together with Flush_E.
- Reset mid-operation (any state, any cnt): the next cycle is RUN with cnt=0. No MC_Done is emitted for the aborted op.

Test Plan:
- Forwarding: Rs1_E=5, Rd_M=5, RegWrite_M=1, Rd_W=5, RegWrite_W=1 -> ForwardA=10. Then RegWrite_M=0 -> ForwardA=01. Rs1_E=0 with Rd_M=0 -> ForwardA=00.
- Load-use: MemRead_E=1, Rd_E=7, Rs2_D=7 -> Stall_F=Stall_D=Flush_E=1 for exactly 1 cycle, Stall_E=0. Same case with Rd_E=0 -> no stall.
- Taken branch: PCSrc_E=1 together with a load-use match -> Flush_D=Flush_E=1, Stall_F=Stall_D=0.
- Multi-cycle, MC_LATENCY=4, MultiCycle_E=1 at cycle t:
  - MC_Start=1 at t only.
  - Stall_E=Bubble_M=1 at t, t+1, t+2.
  - MC_Done=1 and Busy=1 at t+3; stalls 0 at t+3.
  - RUN at t+4.
- Simultaneous: PCSrc_E=1 and MultiCycle_E=1 in RUN -> flush only; MC_Start=0; state stays RUN.
- Reset mid-op: assert reset at t+1 of a MC_LATENCY=4 op -> at t+2 state is RUN, all outputs 0, MC_Done never asserted.
